// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, decode codes and helpers for the multi-cycle controller
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BR, S_HALT
  } state_e;
  typedef enum logic [1:0] {CLS_REG = 2'b00, CLS_IMM = 2'b01, CLS_MEM = 2'b10, CLS_CTRL = 2'b11} class_e;
  typedef enum logic [1:0] {CT_JUMP = 2'b00, CT_BEQZ = 2'b01, CT_BNEZ = 2'b10, CT_HALT = 2'b11} ctrl_e;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  function automatic logic is_load(input class_e c, input logic sub_hi);
    return c == CLS_MEM && !sub_hi;
  endfunction
  function automatic logic is_store(input class_e c, input logic sub_hi);
    return c == CLS_MEM && sub_hi;
  endfunction
  function automatic ctrl_e ctrl_kind(input logic [1:0] sub);
    return ctrl_e'(sub);
  endfunction
endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts unacknowledged memory cycles and flags the timeout cycle
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expire
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  logic [CW-1:0] r_cnt;
  assign o_expire = i_active && !i_ack && r_cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_active && !i_ack && !o_expire) ? r_cnt + 1'b1 : '0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/write-back sequencer with
// req/ack memory handshake, branches, halt, memory timeout and retire counter
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                sel_iord,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_write,
  output logic                sel_pcsrc_const,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_alusrc_reg,
  output logic                sel_alusrc_const,
  output logic                reg_write,
  output logic                sel_wb_mem,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    retire_cnt
);
  state_e           r_state, w_next;
  logic             r_err;
  logic [CNT_W-1:0] r_retire;
  logic             w_retire, w_expire, w_load, w_store;
  class_e           w_cls;
  logic [1:0]       w_sub;
  ctrl_e            w_kind;
  assign w_cls   = class_e'(opcode[OPCODE_W-1 -: 2]);
  assign w_sub   = opcode[OPCODE_W-3 -: 2];
  assign w_kind  = ctrl_kind(w_sub);
  assign w_load  = is_load(w_cls, w_sub[1]);
  assign w_store = is_store(w_cls, w_sub[1]);
  ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (r_state == S_FETCH || r_state == S_MEM),
    .i_ack    (mem_ack),
    .o_expire (w_expire)
  );
  always_comb begin
    w_next           = r_state;
    w_retire         = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    sel_iord         = 1'b0;
    ir_load          = 1'b0;
    pc_inc           = 1'b0;
    pc_write         = 1'b0;
    sel_pcsrc_const  = 1'b0;
    alu_op           = '0;
    sel_alusrc_reg   = 1'b0;
    sel_alusrc_const = 1'b0;
    reg_write        = 1'b0;
    sel_wb_mem       = 1'b0;
    halted           = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
        w_next  = mem_ack ? S_DECODE : w_expire ? S_HALT : S_FETCH;
      end
      S_DECODE: begin
        if (w_cls == CLS_REG || w_cls == CLS_IMM) w_next = S_EXEC;
        else if (w_cls == CLS_MEM) w_next = S_ADDR;
        else if (w_kind == CT_JUMP) begin
          pc_write        = 1'b1;
          sel_pcsrc_const = 1'b1;
          w_retire        = 1'b1;
          w_next          = S_FETCH;
        end else if (w_kind == CT_HALT) begin
          w_retire = 1'b1;
          w_next   = S_HALT;
        end else w_next = S_BR;
      end
      S_EXEC: begin
        alu_op           = opcode[ALU_OP_W-1:0];
        sel_alusrc_reg   = w_cls == CLS_REG;
        sel_alusrc_const = w_cls == CLS_IMM;
        w_next           = S_WB;
      end
      S_ADDR: begin
        alu_op           = ALU_OP_W'(ALU_ADD);
        sel_alusrc_const = 1'b1;
        w_next           = S_MEM;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        sel_iord = 1'b1;
        mem_we   = w_store;
        w_retire = mem_ack && w_store;
        w_next   = mem_ack ? (w_load ? S_WB : S_FETCH) : w_expire ? S_HALT : S_MEM;
      end
      S_WB: begin
        reg_write  = 1'b1;
        sel_wb_mem = w_load;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BR: begin
        alu_op          = ALU_OP_W'(ALU_SUB);
        sel_alusrc_reg  = 1'b1;
        sel_pcsrc_const = 1'b1;
        pc_write        = (w_kind == CT_BEQZ) ? zero : !zero;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_err    <= 1'b0;
      r_retire <= '0;
    end else begin
      r_state  <= w_next;
      r_err    <= r_err | w_expire;
      r_retire <= r_retire + CNT_W'(w_retire);
    end
  assign err        = r_err;
  assign retire_cnt = r_retire;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle scoreboard of expected control outputs
module tb_multicycle_controller;
  import ctrl_pkg::ALU_SUB;
  typedef struct packed {
    logic mem_req, mem_we, sel_iord, ir_load, pc_inc, pc_write, sel_pcsrc_const;
    logic [2:0] alu_op;
    logic sel_alusrc_reg, sel_alusrc_const, reg_write, sel_wb_mem, halted, err;
  } ov_t;
  typedef struct {ov_t e; logic a; logic z;} item_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ack = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_req, mem_we, sel_iord, ir_load, pc_inc, pc_write, sel_pcsrc_const;
  logic [2:0] alu_op;
  logic sel_alusrc_reg, sel_alusrc_const, reg_write, sel_wb_mem, halted, err;
  logic [15:0] retire_cnt;
  ov_t w_obs;
  item_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_ret = '0;
  always #5 clk = ~clk;
  multicycle_controller #(.OPCODE_W(6), .ALU_OP_W(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .sel_iord(sel_iord), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_write(pc_write), .sel_pcsrc_const(sel_pcsrc_const),
    .alu_op(alu_op), .sel_alusrc_reg(sel_alusrc_reg), .sel_alusrc_const(sel_alusrc_const),
    .reg_write(reg_write), .sel_wb_mem(sel_wb_mem), .halted(halted), .err(err),
    .retire_cnt(retire_cnt)
  );
  assign w_obs = {mem_req, mem_we, sel_iord, ir_load, pc_inc, pc_write, sel_pcsrc_const,
                  alu_op, sel_alusrc_reg, sel_alusrc_const, reg_write, sel_wb_mem, halted, err};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input ov_t e, input logic a, input logic z);
    q.push_back('{e: e, a: a, z: z});
  endtask
  task automatic drain(input string tag);
    item_t it;
    for (int i = 0; q.size() > 0; i++) begin
      it = q.pop_front();
      mem_ack = it.a;
      zero = it.z;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(w_obs), 32'(it.e));
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'(w_obs), 32'd0);
    check("rst_retire", 32'(retire_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = '0;
    drive('0, 1'b1, 1'b0);
    drain("idle");
  endtask
  task automatic run(input logic [5:0] op, input int fd, input int md, input logic z, input string tag);
    ov_t v;
    logic [1:0] cls, sub;
    cls = op[5:4];
    sub = op[3:2];
    opcode = op;
    for (int i = 0; i <= fd; i++) begin
      v = '0;
      v.mem_req = 1'b1;
      v.ir_load = (i == fd);
      v.pc_inc = (i == fd);
      drive(v, i == fd, z);
    end
    v = '0;
    v.pc_write = (cls == 2'b11 && sub == 2'b00);
    v.sel_pcsrc_const = (cls == 2'b11 && sub == 2'b00);
    drive(v, 1'b0, z);
    if (cls[1] == 1'b0) begin
      v = '0;
      v.alu_op = op[2:0];
      v.sel_alusrc_reg = (cls == 2'b00);
      v.sel_alusrc_const = (cls == 2'b01);
      drive(v, 1'b0, z);
      v = '0;
      v.reg_write = 1'b1;
      drive(v, 1'b0, z);
    end else if (cls == 2'b10) begin
      v = '0;
      v.alu_op = 3'b010;
      v.sel_alusrc_const = 1'b1;
      drive(v, 1'b0, z);
      for (int i = 0; i <= md; i++) begin
        v = '0;
        v.mem_req = 1'b1;
        v.sel_iord = 1'b1;
        v.mem_we = op[3];
        drive(v, i == md, z);
      end
      if (!op[3]) begin
        v = '0;
        v.reg_write = 1'b1;
        v.sel_wb_mem = 1'b1;
        drive(v, 1'b0, z);
      end
    end else if (sub == 2'b01 || sub == 2'b10) begin
      v = '0;
      v.alu_op = ALU_SUB;
      v.sel_alusrc_reg = 1'b1;
      v.sel_pcsrc_const = 1'b1;
      v.pc_write = (sub == 2'b01) ? z : !z;
      drive(v, 1'b0, z);
    end
    drain(tag);
    exp_ret++;
    check({tag, "_retire"}, 32'(retire_cnt), 32'(exp_ret));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    ov_t v;
    @(posedge clk);
    #1;
    do_reset();
    run(6'b000_010, 0, 0, 1'b0, "reg_add");
    run(6'b10_0000, 0, 2, 1'b0, "load_wait2");
    run(6'b1101_00, 0, 0, 1'b1, "beqz_z1");
    run(6'b1110_00, 0, 0, 1'b1, "bnez_z1");
    run(6'b01_0101, 1, 0, 1'b0, "imm_wait1");
    run(6'b1101_00, 0, 0, 1'b0, "beqz_z0");
    run(6'b10_1000, 0, 1, 1'b0, "store_wait1");
    run(6'b1100_00, 0, 0, 1'b0, "jump");
    run(6'b00_0111, 0, 0, 1'b0, "reg_op7");
    run(6'b1100_00, 3, 0, 1'b0, "ack_at_limit");
    opcode = 6'b10_1000;
    v = '0; v.mem_req = 1'b1; v.ir_load = 1'b1; v.pc_inc = 1'b1;
    drive(v, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0);
    v = '0; v.alu_op = 3'b010; v.sel_alusrc_const = 1'b1;
    drive(v, 1'b0, 1'b0);
    v = '0; v.mem_req = 1'b1; v.sel_iord = 1'b1; v.mem_we = 1'b1;
    drive(v, 1'b0, 1'b0);
    drain("store_pre_rst");
    check("store_waiting", 32'(mem_req & mem_we), 32'd1);
    do_reset();
    check("post_rst_retire", 32'(retire_cnt), 32'd0);
    opcode = 6'b00_0010;
    for (int i = 0; i < 4; i++) begin
      v = '0;
      v.mem_req = 1'b1;
      drive(v, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      v = '0;
      v.halted = 1'b1;
      v.err = 1'b1;
      drive(v, i[0], 1'b0);
    end
    drain("timeout");
    check("timeout_retire", 32'(retire_cnt), 32'd0);
    do_reset();
    opcode = 6'b1111_01;
    v = '0; v.mem_req = 1'b1; v.ir_load = 1'b1; v.pc_inc = 1'b1;
    drive(v, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      v = '0;
      v.halted = 1'b1;
      drive(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("halt_op");
    check("halt_retire", 32'(retire_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
